muxn_arb: RTL and testbench

Parametrised N-input, W-bit registered multiplexer with valid/ready handshaking on every input and on the output. It generalises the team's 2:1 combinational mux into a flow-controlled channel selector. Selection is either an externally driven index or a built-in round-robin arbiter. It sits between multiple producer streams and a single consumer, and holds one registered output word.

---
 rtl/muxn_arb_pkg.sv | 34 +++
 rtl/muxn_arb_rr_pick.sv | 27 ++
 rtl/muxn_arb.sv | 122 ++++++++++++
 tb/tb_muxn_arb.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/muxn_arb_pkg.sv
// Shared types, default parameters and the round-robin search function for muxn_arb.
// Used by both the RTL and the testbench model.
package muxn_pkg;

  localparam int MUXN_W   = 8;
  localparam int MUXN_N   = 4;
  localparam int RR_MAX_N = 64;

  typedef enum logic {
    OCC_EMPTY = 1'b0,
    OCC_FULL  = 1'b1
  } occ_t;

  // Scans last+1, last+2, ... modulo n; wraps at n, not at a power of two.
  function automatic logic rr_next(input logic [RR_MAX_N-1:0] valid,
                                   input int last, input int n,
                                   output int idx);
    logic found;
    int   c;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= RR_MAX_N; k++) begin
      c = (last + k) % n;
      if ((k <= n) && !found && valid[c]) begin
        found = 1'b1;
        idx   = c;
      end else begin
        found = found;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/muxn_arb_rr_pick.sv
// Combinational rotate-priority encoder: first valid channel after `last`, modulo N.
// Only instantiated when MUXN_ARB_RR_EN is defined.
module rr_pick
  import muxn_pkg::*;
#(
  parameter  int N    = MUXN_N,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [SELW-1:0] last,
  output logic [SELW-1:0] grant,
  output logic            found
);

  logic [RR_MAX_N-1:0] valid_ext_s;
  int                  idx_s;

  // Widen to the function's fixed width and run the shared search.
  always_comb begin
    valid_ext_s        = '0;
    valid_ext_s[N-1:0] = valid;
    idx_s              = 0;
    found              = rr_next(valid_ext_s, int'(last), N, idx_s);
    grant              = SELW'(idx_s);
  end

endmodule

// File: rtl/muxn_arb.sv
// N-input registered mux with valid/ready on every port and a one-word output register.
// Define MUXN_ARB_RR_EN for round-robin arbitration; otherwise `sel` picks the channel.
module muxn_arb
  import muxn_pkg::*;
#(
  parameter  int W    = MUXN_W,
  parameter  int N    = MUXN_N,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   out_sel
);

  occ_t            state_r;
  occ_t            state_s;
  logic [W-1:0]    data_r;
  logic [SELW-1:0] sel_r;
  logic [SELW-1:0] grant_s;
  logic            grant_ok_s;
  logic            load_ok_s;
  logic            xfer_in_s;
  logic [N-1:0]    in_ready_s;
  logic [W-1:0]    sel_data_s;

`ifdef MUXN_ARB_RR_EN
  logic [SELW-1:0] last_r;
  logic            unused_sel_s;

  assign unused_sel_s = ^sel;

  rr_pick #(.N(N)) u_rr_pick (
    .valid (in_valid),
    .last  (last_r),
    .grant (grant_s),
    .found (grant_ok_s)
  );

  // Arbiter pointer: advances only when a word is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= SELW'(N - 1);
    end else if (xfer_in_s) begin
      last_r <= grant_s;
    end else begin
      last_r <= last_r;
    end
  end
`else
  localparam logic [SELW:0] N_L = (SELW + 1)'(N);

  assign grant_s    = sel;
  assign grant_ok_s = ({1'b0, sel} < N_L);
`endif

  // Ready decode and data select; rst_n gating keeps in_ready low throughout reset.
  always_comb begin
    load_ok_s  = (state_r == OCC_EMPTY) || out_ready;
    in_ready_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_s == SELW'(i)) begin
        in_ready_s[i] = grant_ok_s && load_ok_s && rst_n;
        sel_data_s    = in_data[i*W +: W];
      end else begin
        in_ready_s[i] = 1'b0;
      end
    end
    xfer_in_s = |(in_ready_s & in_valid);
  end

  assign in_ready = in_ready_s;

  // Occupancy next-state: a load always wins, otherwise a drain empties the register.
  always_comb begin
    state_s = state_r;
    case (state_r)
      OCC_EMPTY: begin
        if (xfer_in_s) state_s = OCC_FULL;
        else           state_s = OCC_EMPTY;
      end
      OCC_FULL: begin
        if (xfer_in_s)      state_s = OCC_FULL;
        else if (out_ready) state_s = OCC_EMPTY;
        else                state_s = OCC_FULL;
      end
      default: state_s = OCC_EMPTY;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= OCC_EMPTY;
    else        state_r <= state_s;
  end

  // Output word and source index; held until the next input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
      sel_r  <= '0;
    end else if (xfer_in_s) begin
      data_r <= sel_data_s;
      sel_r  <= grant_s;
    end else begin
      data_r <= data_r;
      sel_r  <= sel_r;
    end
  end

  assign out_valid = (state_r == OCC_FULL);
  assign out_data  = data_r;
  assign out_sel   = sel_r;

endmodule

// File: tb/tb_muxn_arb.sv
// Directed self-checking bench for muxn_arb (N=3, W=8); covers fixed-select or
// round-robin mode depending on MUXN_ARB_RR_EN.
module tb_muxn_arb;

  localparam int W    = 8;
  localparam int N    = 3;
  localparam int SELW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [SELW-1:0] sel;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SELW-1:0] out_sel;

  int checks = 0;
  int errors = 0;

  muxn_arb #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_check(input logic [W-1:0] dexp, input logic [SELW-1:0] sexp);
    for (int i = 0; i < 5; i++) begin
      in_valid = 3'(i + 3);
      sel      = 2'(i);
      in_data  = {8'(8'h40 + i), 8'(8'h50 + i), 8'(8'h60 + i)};
      #1;
      chk("bp_in_ready", in_ready, 3'b000);
      step();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, dexp);
      chk("bp_sel", out_sel, sexp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 3'b111;
    out_ready = 1'b0;
    sel       = 2'd0;
    in_data   = {8'h33, 8'h22, 8'h11};
    step();
    step();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_sel", out_sel, 2'd0);
    chk("rst_in_ready", in_ready, 3'b000);
    rst_n = 1'b1;

`ifndef MUXN_ARB_RR_EN
    // Fixed select: channel 2 carries 0xA5.
    sel       = 2'd2;
    in_data   = {8'hA5, 8'h22, 8'h11};
    in_valid  = 3'b100;
    out_ready = 1'b1;
    #1;
    chk("fx_in_ready_sel2", in_ready, 3'b100);
    step();
    chk("fx_valid", out_valid, 1'b1);
    chk("fx_data", out_data, 8'hA5);
    chk("fx_sel", out_sel, 2'd2);

    // Out-of-range select: nothing granted, register drains.
    sel      = 2'd3;
    in_valid = 3'b111;
    #1;
    chk("fx_in_ready_sel3", in_ready, 3'b000);
    step();
    chk("fx_sel3_valid", out_valid, 1'b0);
    chk("fx_sel3_data", out_data, 8'hA5);

    // Ready does not depend on valid in fixed mode.
    sel      = 2'd1;
    in_valid = 3'b000;
    #1;
    chk("fx_ready_no_valid", in_ready, 3'b010);

    in_data  = {8'h33, 8'h3C, 8'h11};
    in_valid = 3'b010;
    step();
    chk("fx_load1_data", out_data, 8'h3C);
    chk("fx_load1_sel", out_sel, 2'd1);

    out_ready = 1'b0;
    hold_check(8'h3C, 2'd1);

    // Simultaneous drain and reload.
    out_ready = 1'b1;
    sel       = 2'd0;
    in_valid  = 3'b001;
    in_data   = {8'h33, 8'h22, 8'h5A};
    #1;
    chk("fx_reload_ready", in_ready, 3'b001);
    step();
    chk("fx_reload_valid", out_valid, 1'b1);
    chk("fx_reload_data", out_data, 8'h5A);
    chk("fx_reload_sel", out_sel, 2'd0);

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("fx_async_valid", out_valid, 1'b0);
    chk("fx_async_data", out_data, 8'h00);
    chk("fx_async_ready", in_ready, 3'b000);
    rst_n = 1'b1;
`else
    // Round-robin fairness with every channel valid.
    in_data   = {8'h32, 8'h21, 8'h10};
    in_valid  = 3'b111;
    out_ready = 1'b1;
    sel       = 2'd3;
    #1;
    chk("rr_first_ready", in_ready, 3'b001);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_fair_valid", out_valid, 1'b1);
      chk("rr_fair_sel", out_sel, 2'(i % 3));
      chk("rr_fair_data", out_data, 8'((8'h10 + 8'h11 * (i % 3))));
      chk("rr_fair_ready", in_ready, 3'(1 << ((i + 1) % 3)));
    end

    // last=2, only ch1 valid -> ch1; then only ch0 -> wrap past ch2.
    in_valid = 3'b010;
    step();
    chk("rr_skip_sel", out_sel, 2'd1);
    in_valid = 3'b001;
    #1;
    chk("rr_wrap_ready", in_ready, 3'b001);
    step();
    chk("rr_wrap_sel", out_sel, 2'd0);
    chk("rr_wrap_data", out_data, 8'h10);
    in_valid = 3'b110;
    #1;
    chk("rr_next_ready", in_ready, 3'b010);
    step();
    chk("rr_next_sel", out_sel, 2'd1);

    out_ready = 1'b0;
    hold_check(8'h21, 2'd1);

    // Drain and reload together; last=1 so ch2 is next.
    out_ready = 1'b1;
    in_valid  = 3'b111;
    in_data   = {8'h32, 8'h21, 8'h10};
    #1;
    chk("rr_reload_ready", in_ready, 3'b100);
    step();
    chk("rr_reload_valid", out_valid, 1'b1);
    chk("rr_reload_sel", out_sel, 2'd2);

    in_valid = 3'b000;
    #1;
    chk("rr_none_ready", in_ready, 3'b000);
    step();
    chk("rr_none_valid", out_valid, 1'b0);

    // Load ch0 (last becomes 0), then reset while FULL.
    in_valid  = 3'b001;
    step();
    out_ready = 1'b0;
    in_valid  = 3'b111;
    step();
    chk("rr_pre_rst_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rr_async_valid", out_valid, 1'b0);
    chk("rr_async_data", out_data, 8'h00);
    chk("rr_async_ready", in_ready, 3'b000);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rr_restart_ready", in_ready, 3'b001);
    step();
    chk("rr_restart_sel", out_sel, 2'd0);
    chk("rr_restart_data", out_data, 8'h10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
